// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter between the CPU memory stage and a DMA/debug
// loader, in front of a word-only, single-port data memory.
//
// Sub-word stores are sequenced as read-modify-write (ACCESS reads, MERGE
// writes). Sub-word loads are sign/zero-extended. Misaligned or out-of-range
// requests are answered with an error pulse and never touch memory.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   cpu_req/we/size/unsigned/addr/wdata  CPU request, held until cpu_ready
//   cpu_ready/rdata/err        CPU one-cycle completion pulse, load data, error
//   dma_req/we/addr/wdata      DMA word request, held until dma_ready
//   dma_ready/rdata/err        DMA one-cycle completion pulse, load data, error
//   dm_we/re/addr/wdata        data memory control (word-aligned byte address)
//   dm_rdata                   data memory combinational read data
module dm_arbiter #(
    parameter int DM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_unsigned,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ready,
    output logic [31:0] dma_rdata,
    output logic        dma_err,
    output logic        dm_we,
    output logic        dm_re,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_MERGE  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [29:0] WORD_LIMIT = 30'(DM_WORDS);

    logic [1:0]  state;
    logic        last_owner;
    logic        owner;
    logic        t_we;
    logic [1:0]  t_size;
    logic        t_unsigned;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic        t_err;
    logic [31:0] merge_buf;
    logic [31:0] rdata_q;

    // Grant candidate, evaluated every cycle but only consumed in IDLE.
    logic        g_owner;
    logic        g_we;
    logic [1:0]  g_size;
    logic        g_uns;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic        g_bad;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        // On a tie the side that did not win last time goes next.
        if (cpu_req && dma_req) g_owner = ~last_owner;
        else                    g_owner = dma_req ? OWN_DMA : OWN_CPU;

        if (g_owner == OWN_DMA) begin
            g_we    = dma_we;
            g_size  = SZ_W;
            g_uns   = 1'b0;
            g_addr  = dma_addr;
            g_wdata = dma_wdata;
        end else begin
            g_we    = cpu_we;
            g_size  = cpu_size;
            g_uns   = cpu_unsigned;
            g_addr  = cpu_addr;
            g_wdata = cpu_wdata;
        end

        g_bad = (g_size == 2'b11)
             || (g_size == SZ_H && g_addr[0])
             || (g_size == SZ_W && g_addr[1:0] != 2'b00)
             || (g_addr[31:2] >= WORD_LIMIT);
    end

    // Lane extraction and extension of the word read in ACCESS.
    logic [7:0]  lane8;
    logic [15:0] lane16;
    logic [31:0] load_val;

    always_comb begin
        case (t_addr[1:0])
            2'd0:    lane8 = dm_rdata[7:0];
            2'd1:    lane8 = dm_rdata[15:8];
            2'd2:    lane8 = dm_rdata[23:16];
            default: lane8 = dm_rdata[31:24];
        endcase
        lane16 = t_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];

        case (t_size)
            SZ_B:    load_val = t_unsigned ? {24'b0, lane8} : {{24{lane8[7]}}, lane8};
            SZ_H:    load_val = t_unsigned ? {16'b0, lane16} : {{16{lane16[15]}}, lane16};
            default: load_val = dm_rdata;
        endcase
    end

    // Read-modify-write merge: replace the addressed lane of the saved word.
    logic [31:0] merged;

    always_comb begin
        merged = merge_buf;
        if (t_size == SZ_B) begin
            case (t_addr[1:0])
                2'd0:    merged[7:0]   = t_wdata[7:0];
                2'd1:    merged[15:8]  = t_wdata[7:0];
                2'd2:    merged[23:16] = t_wdata[7:0];
                default: merged[31:24] = t_wdata[7:0];
            endcase
        end else if (t_addr[1]) begin
            merged[31:16] = t_wdata[15:0];
        end else begin
            merged[15:0] = t_wdata[15:0];
        end
    end

    // Memory side is decoded from state and latched fields only, so an async
    // reset removes dm_we without waiting for a clock edge.
    always_comb begin
        dm_we    = 1'b0;
        dm_re    = 1'b0;
        dm_addr  = 32'b0;
        dm_wdata = 32'b0;
        case (state)
            S_ACCESS: begin
                dm_re   = 1'b1;
                dm_addr = {t_addr[31:2], 2'b00};
                if (t_we && t_size == SZ_W) begin
                    dm_we    = 1'b1;
                    dm_wdata = t_wdata;
                end
            end
            S_MERGE: begin
                dm_we    = 1'b1;
                dm_addr  = {t_addr[31:2], 2'b00};
                dm_wdata = merged;
            end
            default: ;
        endcase
    end

    assign cpu_ready = (state == S_RESP) && (owner == OWN_CPU);
    assign dma_ready = (state == S_RESP) && (owner == OWN_DMA);
    assign cpu_err   = cpu_ready && t_err;
    assign dma_err   = dma_ready && t_err;
    assign cpu_rdata = rdata_q;
    assign dma_rdata = rdata_q;

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values; datapath registers are reset as well so rdata and
    // the memory outputs come up as zero rather than X.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            last_owner <= OWN_DMA;
            owner      <= OWN_CPU;
            t_we       <= 1'b0;
            t_size     <= SZ_B;
            t_unsigned <= 1'b0;
            t_addr     <= 32'b0;
            t_wdata    <= 32'b0;
            t_err      <= 1'b0;
            merge_buf  <= 32'b0;
            rdata_q    <= 32'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req || dma_req) begin
                        owner      <= g_owner;
                        last_owner <= g_owner;
                        t_we       <= g_we;
                        t_size     <= g_size;
                        t_unsigned <= g_uns;
                        t_addr     <= g_addr;
                        t_wdata    <= g_wdata;
                        t_err      <= g_bad;
                        rdata_q    <= 32'b0;
                        state      <= g_bad ? S_RESP : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!t_we) begin
                        rdata_q <= load_val;
                        state   <= S_RESP;
                    end else if (t_size == SZ_W) begin
                        state <= S_RESP;
                    end else begin
                        merge_buf <= dm_rdata;
                        state     <= S_MERGE;
                    end
                end
                S_MERGE: state <= S_RESP;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: self-checking bench for dm_arbiter. A behavioural model built
// from byte-lane arithmetic predicts error, load data, latency and memory
// contents for directed and random transactions from both requesters.
module tb_dm_arbiter;

    localparam int DM_WORDS = 128;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cpu_req, cpu_we, cpu_unsigned;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_ready, cpu_err;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_ready, dma_err;
    logic [31:0] dma_rdata;
    logic        dm_we, dm_re;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;

    always #5 clk = ~clk;

    dm_arbiter #(.DM_WORDS(DM_WORDS)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ready(dma_ready), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .dm_we(dm_we), .dm_re(dm_re), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata)
    );

    // Data memory attached to the DUT, plus a backdoor port for preloading.
    logic [31:0] dut_mem [DM_WORDS];
    logic [31:0] ref_mem [DM_WORDS];
    logic        bd_we = 1'b0;
    logic [6:0]  bd_idx = 7'd0;
    logic [31:0] bd_data = 32'd0;

    assign dm_rdata = dut_mem[dm_addr[8:2]];

    always @(posedge clk) begin
        if (bd_we)      dut_mem[bd_idx] <= bd_data;
        else if (dm_we) dut_mem[dm_addr[8:2]] <= dm_wdata;
    end

    // Monitor: counts memory strobes and records the order of ready pulses.
    int          we_cnt = 0;
    int          re_cnt = 0;
    int          both_rdy = 0;
    logic [31:0] last_we_addr = 32'd0;
    bit          grant_q[$];

    always @(negedge clk) begin
        if (dm_we) begin
            we_cnt++;
            last_we_addr = dm_addr;
        end
        if (dm_re) re_cnt++;
        if (cpu_ready && dma_ready) both_rdy++;
        if (cpu_ready) grant_q.push_back(1'b0);
        if (dma_ready) grant_q.push_back(1'b1);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
        int bytes;
        if (size == 2'b11) return 1'b1;
        bytes = 1 << size;
        if ((addr & 32'(bytes - 1)) != 32'd0) return 1'b1;
        return (addr >> 2) >= 32'(DM_WORDS);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                               input bit uns, input logic [31:0] addr);
        int nbits;
        int sh;
        longint unsigned mask;
        longint unsigned v;
        nbits = 8 << size;
        sh    = 8 * int'(addr[1:0]);
        mask  = (64'd1 << nbits) - 64'd1;
        v     = ({32'd0, word} >> sh) & mask;
        if (!uns && v[nbits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] size,
                                                input logic [31:0] addr, input logic [31:0] wdata);
        int nbits;
        int sh;
        longint unsigned mask;
        longint unsigned v;
        nbits = 8 << size;
        sh    = 8 * int'(addr[1:0]);
        mask  = ((64'd1 << nbits) - 64'd1) << sh;
        v     = ({32'd0, old} & ~mask) | (({32'd0, wdata}) << sh & mask);
        return v[31:0];
    endfunction

    task automatic bd_write(input int idx, input logic [31:0] data);
        bd_we   = 1'b1;
        bd_idx  = 7'(idx);
        bd_data = data;
        ref_mem[idx] = data;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issue one transaction from a negedge. With chk set, the DUT is expected
    // to be idle and uncontended, so latency and strobe counts are checked.
    task automatic do_txn(input bit is_dma, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit keep_req, input bit chk, output logic [31:0] obs_rdata);
        int cycles;
        int we0;
        int re0;
        bit got;
        bit exp_err;
        int idx;
        logic [1:0] msize;
        msize = is_dma ? 2'b10 : size;
        if (is_dma) begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_unsigned = uns;
            cpu_addr = addr; cpu_wdata = wdata;
        end
        we0 = we_cnt;
        re0 = re_cnt;
        cycles = 0;
        got = 1'b0;
        while (!got && cycles < 20) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            got = is_dma ? dma_ready : cpu_ready;
        end
        obs_rdata = is_dma ? dma_rdata : cpu_rdata;
        check(is_dma ? "dma_ready_seen" : "cpu_ready_seen", 32'(got), 32'd1);
        if (got) begin
            exp_err = model_err(msize, addr);
            idx = int'(addr >> 2);
            check(is_dma ? "dma_err" : "cpu_err", 32'(is_dma ? dma_err : cpu_err), 32'(exp_err));
            if (!exp_err && !we)
                check(is_dma ? "dma_rdata" : "cpu_rdata", obs_rdata,
                      model_load(ref_mem[idx], msize, uns, addr));
            if (chk) begin
                check("latency", 32'(cycles), exp_err ? 32'd1 : ((we && msize != 2'b10) ? 32'd3 : 32'd2));
                check("dm_we_count", 32'(we_cnt - we0), (!exp_err && we) ? 32'd1 : 32'd0);
                check("dm_re_count", 32'(re_cnt - re0), exp_err ? 32'd0 : 32'd1);
            end
            if (!exp_err && we) begin
                ref_mem[idx] = model_store(ref_mem[idx], msize, addr, wdata);
                check("mem_word", dut_mem[idx], ref_mem[idx]);
            end
        end
        if (!keep_req) begin
            if (is_dma) dma_req = 1'b0;
            else        cpu_req = 1'b0;
            @(negedge clk);
        end
    endtask

    logic [31:0] rd, d0, d1;
    int          n0;

    initial begin
        rstn = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_unsigned = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        @(negedge clk);
        for (int i = 0; i < DM_WORDS; i++) bd_write(i, $urandom);

        // Reset values
        check("rst_ctrl", {26'd0, cpu_ready, cpu_err, dma_ready, dma_err, dm_we, dm_re}, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_dma_rdata", dma_rdata, 32'd0);
        check("rst_dm_addr", dm_addr, 32'd0);
        check("rst_dm_wdata", dm_wdata, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Word store then load
        do_txn(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 1, rd);
        check("sw_dm_addr", last_we_addr, 32'h10);
        do_txn(0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 1, rd);
        check("lw_10", rd, 32'hDEADBEEF);

        // Byte store by read-modify-write, then sub-word loads
        bd_write(8, 32'h11223344);
        do_txn(0, 1, 2'b00, 0, 32'h21, 32'h000000AA, 0, 1, rd);
        check("sb_merge", dut_mem[8], 32'h1122AA44);
        do_txn(0, 0, 2'b00, 0, 32'h21, 32'h0, 0, 1, rd);
        check("lb_signed", rd, 32'hFFFFFFAA);
        do_txn(0, 0, 2'b01, 1, 32'h22, 32'h0, 0, 1, rd);
        check("lhu", rd, 32'h00001122);

        // Error cases: misaligned CPU word load, out-of-range DMA store
        do_txn(0, 0, 2'b10, 0, 32'h22, 32'h0, 0, 1, rd);
        do_txn(1, 1, 2'b10, 0, 32'h200, 32'h12345678, 0, 1, rd);
        check("oor_word127", dut_mem[127], ref_mem[127]);

        // Continuous contention: grants alternate starting with CPU
        n0 = grant_q.size();
        fork
            begin
                do_txn(0, 1, 2'b10, 0, 32'h30, 32'hCAFE0001, 1, 0, d0);
                do_txn(0, 0, 2'b01, 0, 32'h36, 32'h0, 0, 0, d0);
            end
            begin
                do_txn(1, 1, 2'b10, 0, 32'h38, 32'hA5A5F00D, 1, 0, d1);
                do_txn(1, 0, 2'b10, 0, 32'h30, 32'h0, 0, 0, d1);
            end
        join
        check("fair_count", 32'(grant_q.size() - n0), 32'd4);
        for (int i = 0; i < 4; i++)
            check("fair_order", 32'(grant_q[n0 + i]), 32'(i % 2));

        // Random single-requester traffic, including the range boundary
        for (int t = 0; t < 40; t++) begin
            bit          dsel;
            bit          w;
            bit          u;
            logic [1:0]  sz;
            logic [31:0] a;
            dsel = 1'($urandom_range(0, 1));
            w    = 1'($urandom_range(0, 1));
            u    = 1'($urandom_range(0, 1));
            sz   = dsel ? 2'b10 : 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = 32'h1F0 + 32'($urandom_range(0, 31));
            else                           a = 32'($urandom_range(0, 63));
            do_txn(dsel, w, sz, u, a, $urandom, 0, 1, rd);
        end

        // Async reset in the middle of a halfword store's MERGE cycle
        n0 = grant_q.size();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b01; cpu_unsigned = 1'b0;
        cpu_addr = 32'h32; cpu_wdata = 32'h0000BEEF;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("merge_dm_we", 32'(dm_we), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("rst_async_we", 32'(dm_we), 32'd0);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_no_ready", 32'(grant_q.size() - n0), 32'd0);
        check("rst_word_kept", dut_mem[12], ref_mem[12]);
        rstn = 1'b1;
        @(negedge clk);

        // After reset the CPU wins the first tie
        n0 = grant_q.size();
        fork
            do_txn(0, 1, 2'b10, 0, 32'h40, 32'h0BADF00D, 0, 0, d0);
            do_txn(1, 0, 2'b10, 0, 32'h40, 32'h0, 0, 0, d1);
        join
        check("post_rst_first", 32'(grant_q[n0]), 32'd0);
        check("post_rst_second", 32'(grant_q[n0 + 1]), 32'd1);
        check("dma_sees_cpu_write", d1, 32'h0BADF00D);
        check("never_both_ready", 32'(both_rdy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
